// File: rtl/perf_pkg.sv
// Shared definitions for the perf_stat_unit performance-statistics block.
// State encodings, channel roles and default sizing.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    localparam int CH_CYCLES    = 0;
    localparam int CH_COND_BR   = 1;
    localparam int CH_UNCOND_BR = 2;
    localparam int CH_USER      = 3;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_SEL_W = 4;

endpackage

// File: rtl/perf_stat_unit_if.sv
// Core-side bundle for perf_stat_unit: control strobes, events and readout.
// master = core/test side, slave = statistics block.
interface perf_stat_unit_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int SEL_W = 4
);
    logic             go;
    logic             halt;
    logic [N_CH-1:0]  ev;
    logic             clr;
    logic             snap;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_snap;
    logic [CNT_W-1:0] rd_data;
    logic [N_CH-1:0]  ovf;
    logic             snap_valid;
    logic [1:0]       state_o;

    modport master (
        output go, halt, ev, clr, snap, rd_sel, rd_snap,
        input  rd_data, ovf, snap_valid, state_o
    );

    modport slave (
        input  go, halt, ev, clr, snap, rd_sel, rd_snap,
        output rd_data, ovf, snap_valid, state_o
    );
endinterface

// File: rtl/perf_counter.sv
// One statistics channel: live count, snapshot copy and sticky overflow.
// PERF_SAT_EN defined: saturate at all-ones; otherwise wrap to zero.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_snap,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_snap,
    output logic             o_ovf
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_snap;
    logic             r_ovf;
    logic             w_full;

    assign w_full = &r_cnt;

    // Snapshot takes the value before this edge's increment.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt  <= '0;
            r_snap <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (i_snap) begin
                r_snap <= r_cnt;
            end
            if (i_inc) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
`ifdef PERF_SAT_EN
                    r_cnt <= r_cnt;
`else
                    r_cnt <= '0;
`endif
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_snap = r_snap;
    assign o_ovf  = r_ovf;
endmodule

// File: rtl/perf_stat_unit.sv
// Run/halt-gated performance counters with snapshot bank and muxed readout.
// Optional PERF_SAT_EN selects saturating counters (see perf_counter).
module perf_stat_unit
    import perf_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SEL_W = DEF_SEL_W
) (
    input logic             clk,
    input logic             rst,
    perf_stat_unit_if.slave bus
);
    state_t           r_state;
    state_t           w_next;
    logic             w_run;
    logic [CNT_W-1:0] w_cnt [N_CH];
    logic [CNT_W-1:0] w_snp [N_CH];
    logic [N_CH-1:0]  w_ovf;
    logic [CNT_W-1:0] w_rd;
    logic [CNT_W-1:0] r_rd;
    logic             r_snap_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // halt beats go in RUN; FROZEN leaves only through clr.
    always_comb begin
        w_next = r_state;
        if (bus.clr) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.go) w_next = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.halt)     w_next = ST_FROZEN;
                    else if (!bus.go) w_next = ST_IDLE;
                end
                ST_FROZEN: w_next = ST_FROZEN;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    assign w_run = (r_state == ST_RUN);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        perf_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .i_clr  (bus.clr),
            .i_snap (bus.snap),
            .i_inc  (w_run & bus.ev[g]),
            .o_cnt  (w_cnt[g]),
            .o_snap (w_snp[g]),
            .o_ovf  (w_ovf[g])
        );
    end

    // Unmatched selects fall through to zero.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                w_rd = bus.rd_snap ? w_snp[i] : w_cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd         <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_rd <= w_rd;
            if (bus.clr) begin
                r_snap_valid <= 1'b0;
            end else if (bus.snap) begin
                r_snap_valid <= 1'b1;
            end
        end
    end

    assign bus.rd_data    = r_rd;
    assign bus.ovf        = w_ovf;
    assign bus.snap_valid = r_snap_valid;
    assign bus.state_o    = r_state;
endmodule

// File: tb/tb_perf_stat_unit.sv
// Bench for perf_stat_unit: directed sequences, a vector table and
// randomized traffic against a behavioural reference model.
module tb_perf_stat_unit;
    localparam int NC   = 4;
    localparam int CW   = 8;
    localparam int SW   = 4;
    localparam int MAXV = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    perf_stat_unit_if #(.N_CH(NC), .CNT_W(CW), .SEL_W(SW)) bus ();

    perf_stat_unit #(
        .N_CH  (NC),
        .CNT_W (CW),
        .SEL_W (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_st;
    int m_cnt [NC];
    int m_snp [NC];
    bit [NC-1:0] m_ovf;
    bit m_sv;
    int m_rd;

    function automatic void model_step();
        int sel;
        sel = int'(bus.rd_sel);
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                m_cnt[i] = 0;
                m_snp[i] = 0;
            end
            m_ovf = '0;
            m_sv  = 0;
            m_st  = 0;
            m_rd  = 0;
            return;
        end
        if (sel < NC) m_rd = bus.rd_snap ? m_snp[sel] : m_cnt[sel];
        else          m_rd = 0;
        if (bus.clr) begin
            for (int i = 0; i < NC; i++) begin
                m_cnt[i] = 0;
                m_snp[i] = 0;
            end
            m_ovf = '0;
            m_sv  = 0;
            m_st  = 0;
            return;
        end
        if (bus.snap) begin
            for (int i = 0; i < NC; i++) m_snp[i] = m_cnt[i];
            m_sv = 1;
        end
        if (m_st == 1) begin
            for (int i = 0; i < NC; i++) begin
                if (bus.ev[i]) begin
                    if (m_cnt[i] + 1 > MAXV) begin
                        m_ovf[i] = 1'b1;
`ifdef PERF_SAT_EN
                        m_cnt[i] = MAXV;
`else
                        m_cnt[i] = 0;
`endif
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
        if (m_st == 0 && bus.go)    m_st = 1;
        else if (m_st == 1) begin
            if (bus.halt)           m_st = 2;
            else if (!bus.go)       m_st = 0;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input bit go, input bit halt, input bit [NC-1:0] ev,
                         input bit clr, input bit snap, input int sel,
                         input bit rs);
        bus.go      = go;
        bus.halt    = halt;
        bus.ev      = ev;
        bus.clr     = clr;
        bus.snap    = snap;
        bus.rd_sel  = SW'(sel);
        bus.rd_snap = rs;
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        bit          go;
        bit          halt;
        bit [NC-1:0] ev;
        bit          clr;
        int          sel;
        int          exp_st;
        int          exp_rd;
    } vec_t;

    function automatic vec_t mkv(bit go, bit halt, bit [NC-1:0] ev, bit clr,
                                 int sel, int st, int rd);
        vec_t v;
        v.go = go; v.halt = halt; v.ev = ev; v.clr = clr;
        v.sel = sel; v.exp_st = st; v.exp_rd = rd;
        return v;
    endfunction

    vec_t tv [16];

    initial begin
        // Halt-freeze sequence: 5 run cycles plus the halt cycle count.
        tv[0] = mkv(1, 0, 4'b0000, 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) tv[i] = mkv(1, 0, 4'b0111, 0, 0, 1, i - 1);
        tv[6] = mkv(1, 1, 4'b0111, 0, 0, 2, 5);
        for (int i = 7; i <= 11; i++) tv[i] = mkv(1, 0, 4'b0111, 0, (i - 7) % 3, 2, 6);
        tv[12] = mkv(1, 0, 4'b0111, 1, 2, 0, 6);
        tv[13] = mkv(0, 0, 4'b0000, 0, 0, 0, 0);
        tv[14] = mkv(0, 0, 4'b0000, 0, 1, 0, 0);
        tv[15] = mkv(0, 0, 4'b0000, 0, 2, 0, 0);

        setin(0, 0, '0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_rd", bus.rd_data, 0);
        chk("reset_ovf", bus.ovf, 0);
        chk("reset_state", bus.state_o, 0);
        chk("reset_sv", bus.snap_valid, 0);

        // Start and count 10 cycles on channel 0
        setin(1, 0, 4'b0000, 0, 0, 0, 0);
        tick();
        chk("start_state", bus.state_o, 1);
        for (int i = 0; i < 10; i++) begin
            setin(1, 0, 4'b0001, 0, 0, 0, 0);
            tick();
            chk("run_state", bus.state_o, 1);
        end
        setin(0, 0, 4'b0000, 0, 0, 0, 0);
        tick();
        chk("stop_state", bus.state_o, 0);
        chk("stop_ch0", bus.rd_data, 10);

        // Halt freeze via table
        setin(0, 0, '0, 1, 0, 0, 0);
        tick();
        foreach (tv[k]) begin
            setin(tv[k].go, tv[k].halt, tv[k].ev, tv[k].clr, 0, tv[k].sel, 0);
            tick();
            chk($sformatf("tv%0d_state", k), bus.state_o, tv[k].exp_st);
            chk($sformatf("tv%0d_rd", k), bus.rd_data, tv[k].exp_rd);
        end

        // Wrap / saturate on channel 1
        setin(0, 0, '0, 1, 0, 1, 0);
        tick();
        setin(1, 0, 4'b0000, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < MAXV; i++) begin
            setin(1, 0, 4'b0010, 0, 0, 1, 0);
            tick();
        end
        setin(1, 0, 4'b0000, 0, 0, 1, 0);
        tick();
        chk("wrap_full", bus.rd_data, MAXV);
        chk("wrap_noovf", bus.ovf, 0);
        setin(1, 0, 4'b0010, 0, 0, 1, 0);
        tick();
        setin(1, 0, 4'b0000, 0, 0, 1, 0);
        tick();
`ifdef PERF_SAT_EN
        chk("wrap_val", bus.rd_data, MAXV);
`else
        chk("wrap_val", bus.rd_data, 0);
`endif
        chk("wrap_ovf", bus.ovf, 4'b0010);

        // Snapshot atomicity
        setin(0, 0, '0, 1, 0, 0, 0);
        tick();
        chk("clr_ovf", bus.ovf, 0);
        setin(1, 0, 4'b0000, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            setin(1, 0, 4'b0001, 0, 0, 0, 0);
            tick();
        end
        setin(1, 0, 4'b0001, 0, 1, 0, 0);
        tick();
        chk("snap_rd_pre", bus.rd_data, 20);
        chk("snap_valid", bus.snap_valid, 1);
        setin(1, 0, 4'b0001, 0, 0, 0, 0);
        tick();
        chk("snap_live", bus.rd_data, 21);
        setin(1, 0, 4'b0001, 0, 0, 0, 1);
        tick();
        chk("snap_copy", bus.rd_data, 20);

        // clr beats snap and events
        setin(1, 0, 4'b1111, 1, 1, 0, 0);
        tick();
        chk("prio_state", bus.state_o, 0);
        chk("prio_sv", bus.snap_valid, 0);
        chk("prio_ovf", bus.ovf, 0);
        for (int i = 0; i < NC; i++) begin
            setin(0, 0, '0, 0, 0, i, 1);
            tick();
            chk($sformatf("prio_snp%0d", i), bus.rd_data, 0);
            setin(0, 0, '0, 0, 0, i, 0);
            tick();
            chk($sformatf("prio_cnt%0d", i), bus.rd_data, 0);
        end

        // rst mid-run
        setin(1, 0, 4'b0000, 0, 0, 0, 0);
        tick();
        setin(1, 0, 4'b1111, 0, 1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            setin(1, 0, 4'b1111, 0, 0, 0, 0);
            tick();
        end
        chk("pre_rst_rd", bus.rd_data, 3);
        rst = 1'b1;
        tick();
        chk("rst_rd", bus.rd_data, 0);
        chk("rst_state", bus.state_o, 0);
        chk("rst_sv", bus.snap_valid, 0);
        rst = 1'b0;
        setin(0, 0, '0, 0, 0, 3, 0);
        tick();
        chk("rst_cnt3", bus.rd_data, 0);

        // Out-of-range select
        setin(1, 0, 4'b0000, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            setin(1, 0, 4'b1111, 0, 1, 0, 0);
            tick();
        end
        setin(1, 0, 4'b1111, 0, 0, 5, 0);
        tick();
        chk("sel5", bus.rd_data, 0);
        setin(1, 0, 4'b1111, 0, 0, 15, 1);
        tick();
        chk("sel15", bus.rd_data, 0);
        setin(1, 0, 4'b0000, 0, 0, 0, 0);
        tick();
        chk("sel0_after", bus.rd_data, 5);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            setin($urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  NC'($urandom),
                  $urandom_range(0, 63) == 0,
                  $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1);
            tick();
            chk("rnd_rd", bus.rd_data, m_rd);
            chk("rnd_ovf", bus.ovf, m_ovf);
            chk("rnd_sv", bus.snap_valid, m_sv);
            chk("rnd_state", bus.state_o, m_st);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/perf_stat_unit.md
Name: perf_stat_unit

Overview:
- Parametrised performance-statistics block for the MIPS cores.
- Generalises the fixed cycle, conditional-branch and unconditional-branch counters to N_CH channels of width CNT_W.
- Adds a run/halt state machine, synchronous clear, an atomic snapshot bank, per-channel overflow flags and a muxed readout port for the LED/display path.
- Sits beside the core: one event strobe per channel, with `go`/`halt` from the core's PC-enable logic.

Parameters:
- N_CH, 4, number of counter channels (2..16)
- CNT_W, 32, counter width in bits (8..64)
- SEL_W, 4, readout select width; must satisfy 2**SEL_W >= N_CH

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- go  input  1  core running strobe; level, sampled every cycle
- halt  input  1  core halt request (syscall halt); level
- ev  input  N_CH  per-channel event strobes, one increment per cycle when high
- clr  input  1  synchronous clear of counters, snapshots and overflow flags
- snap  input  1  copy all live counters to snapshot bank
- rd_sel  input  SEL_W  channel selected for readout
- rd_snap  input  1  readout source: 0 = live counter, 1 = snapshot
- rd_data  output  CNT_W  selected counter value, registered
- ovf  output  N_CH  sticky per-channel overflow/saturation flags
- snap_valid  output  1  high once a snapshot has been taken since the last clr/rst
- state_o  output  2  current FSM state encoding (debug/LED)

Behaviour:
- Reset (rst=1 at edge):
  - all counters, snapshots, ovf, snap_valid and rd_data go to 0
  - FSM goes to IDLE
  - rst has priority over every other input, including mid-count.
- FSM states: IDLE=0, RUN=1, FROZEN=2.
  - IDLE -> RUN when go=1.
  - RUN -> FROZEN when halt=1. halt wins over go in the same cycle.
  - RUN -> IDLE when go=0 and halt=0.
  - FROZEN -> IDLE only on clr=1. go is ignored in FROZEN.
  - Any state -> IDLE on clr=1.
- Counting:
  - A channel increments by 1 on an edge only when the current state is RUN and ev[i]=1 in that cycle.
  - The transition cycle itself counts: the cycle in which halt is first seen in RUN still counts its events.
  - Channel 0 is by convention wired to go and acts as the total-cycle counter. The block treats all channels identically.
- Width and wrap:
  - Counters are unsigned CNT_W.
  - At all-ones with an increment, the counter wraps to 0 and ovf[i] sets.
  - ovf is sticky until clr or rst.
- Clear: clr=1 zeroes counters, snapshots, ovf and snap_valid on the next edge. clr has priority over increments and snap in the same cycle.
- Snapshot:
  - snap=1 (without clr) copies the pre-increment values of all channels, i.e. the values before that edge's increments.
  - All channels are captured in the same edge.
  - snap_valid sets.
  - snap is allowed in any state.
- Readout:
  - rd_data is registered, 1-cycle latency from rd_sel/rd_snap.
  - It reflects the counter value before the same edge's update.
  - rd_sel >= N_CH returns 0.
- state_o is the combinational view of the current state register.

Optional Feature:
- PERF_SAT_EN
- Defined: counters saturate at all-ones instead of wrapping. ovf[i] sets on the first increment attempted while saturated. A saturated value holds until clr/rst.
- Not defined: wrap-around behaviour as described in Behaviour.

Decomposition:
- perf_pkg holds:
  - state encodings ST_IDLE / ST_RUN / ST_FROZEN
  - channel index constants CH_CYCLES=0, CH_COND_BR=1, CH_UNCOND_BR=2, CH_USER=3
  - default N_CH/CNT_W constants.
- One sub-module, perf_counter: a single channel with live register, snapshot register, ovf flag, and the wrap/saturate logic under PERF_SAT_EN. It is instantiated N_CH times via generate.
- The FSM and readout mux stay in the top.

Test Plan:
- Reset and start:
  - After reset, rd_data=0, ovf=0, state_o=0.
  - go=1 and ev=4'b0001 for 10 cycles, then go=0. Expect state_o=1 during the run and channel 0 reads 10.
- Halt freeze:
  - In RUN, hold ev=4'b0111. Assert halt at cycle 5, then keep ev and go high for 5 more cycles.
  - Expect channels 0..2 = 6 (the halt cycle counts), state_o=2, and counts unchanged afterwards.
  - Then clr=1: all counters = 0 and state_o=0.
- Wrap/overflow:
  - CNT_W=8, 255 events on channel 1, then 1 more.
  - Without PERF_SAT_EN: value 0, ovf[1]=1.
  - With PERF_SAT_EN: value 255, ovf[1]=1.
- Snapshot atomicity:
  - Channel 0 at 20 in RUN with ev[0]=1. Pulse snap.
  - Next cycle: live=21; rd_snap=1, rd_sel=0 returns 20 one cycle later; snap_valid=1.
- Priority:
  - Same cycle clr=1, snap=1, ev=all ones. Expect counters=0, snapshots=0, snap_valid=0.
  - rst asserted mid-run forces IDLE and all zeros.
- Readout range: rd_sel=5 with N_CH=4 -> rd_data=0 one cycle later.
